// File: rtl/hyperbus_ddr_deser_if.sv
// Bundle between the HyperBus DDR deserializer and its environment.
//
// Signals (names keep the block-level _i/_o sense as seen by the deserializer):
//   enable_i     capture enable, sampled on both clock edges
//   data_i       WIDTH DDR data lanes
//   pos_first_i  pair ordering (1: rising-edge sample in the low half)
//   clear_i      synchronous flush of assembler, FIFO and overflow flag
//   word_o       FIFO head word, all-zero while empty
//   valid_o      FIFO non-empty
//   ready_i      consumer accepts word_o
//   overflow_o   sticky: a completed word was dropped
//   level_o      FIFO occupancy
//
// Handshake: a word transfers on a rising edge where valid_o=1 and ready_i=1.
// valid_o never depends on ready_i; ready_i is ignored while valid_o=0, and
// word_o stays stable while valid_o=1 and ready_i=0.
//
// Modports: master = producer/consumer environment, slave = deserializer.
interface hyperbus_ddr_deser_if #(
  parameter int WIDTH = 8,
  parameter int BEATS = 2,
  parameter int DEPTH = 2
);
  localparam int WW = 2 * WIDTH * BEATS;
  localparam int LW = $clog2(DEPTH) + 1;

  logic             enable_i;
  logic [WIDTH-1:0] data_i;
  logic             pos_first_i;
  logic             clear_i;
  logic [WW-1:0]    word_o;
  logic             valid_o;
  logic             ready_i;
  logic             overflow_o;
  logic [LW-1:0]    level_o;

  modport master (
    output enable_i, data_i, pos_first_i, clear_i, ready_i,
    input  word_o, valid_o, overflow_o, level_o
  );

  modport slave (
    input  enable_i, data_i, pos_first_i, clear_i, ready_i,
    output word_o, valid_o, overflow_o, level_o
  );
endinterface

// File: rtl/hyperbus_ddr_deser.sv
// HyperBus DDR deserializer: samples data lanes on both clock edges, pairs
// each rising/falling sample, assembles BEATS pairs into one word (beat 0 in
// the LSBs) and queues finished words in a DEPTH-entry FIFO.
//
// Ports:
//   clk_i   single clock, both edges sample data
//   rst_ni  synchronous active-low reset (rising edge; neg_q on falling edge)
//   bus     hyperbus_ddr_deser_if.slave -- capture inputs, FIFO output side
module hyperbus_ddr_deser #(
  parameter int WIDTH = 8,
  parameter int BEATS = 2,
  parameter int DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hyperbus_ddr_deser_if.slave   bus
);
  localparam int PW = 2 * WIDTH;
  localparam int WW = PW * BEATS;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [WIDTH-1:0] pos_q, neg_q;
  logic             en_q;
  logic [PW-1:0]    pair_q;
  logic             pair_vld_q;
  logic [CW-1:0]    cnt_q;
  logic [WW-1:0]    acc_q, acc_next;
  logic [WW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic             ovf_q;

  logic last, push, pop, full, wr_en, ovf_set;

  // Rising-edge capture and pairing. pair_q forms from the rising sample of
  // the previous cycle and the falling sample between the two edges; en_q
  // carries that cycle's enable so pair_vld_q lines up with the pair.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pos_q  <= '0;
      en_q   <= 1'b0;
      pair_q <= '0;
    end else begin
      if (bus.enable_i) pos_q <= bus.data_i;
      en_q   <= bus.enable_i;
      pair_q <= bus.pos_first_i ? {neg_q, pos_q} : {pos_q, neg_q};
    end
  end

  always_ff @(negedge clk_i) begin
    if (!rst_ni)           neg_q <= '0;
    else if (bus.enable_i) neg_q <= bus.data_i;
  end

  // Accumulator with the current pair merged into slot cnt_q; this is also
  // the word pushed when the last beat arrives.
  always_comb begin
    acc_next = acc_q;
    for (int b = 0; b < BEATS; b++) begin
      if (CW'(b) == cnt_q) acc_next[b*PW +: PW] = pair_q;
    end
  end

  assign last    = (cnt_q == LAST);
  assign push    = pair_vld_q && last;
  assign pop     = (level_q != '0) && bus.ready_i;
  assign full    = (level_q == LW'(DEPTH));
  // A pop in the same cycle frees the slot, so a push while full still fits.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.clear_i) begin
      pair_vld_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      pair_vld_q <= en_q;
      if (pair_vld_q) begin
        acc_q <= acc_next;
        cnt_q <= last ? '0 : cnt_q + CW'(1);
      end
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (pop)   rptr_q <= rptr_q + AW'(1);
      if (wr_en && !pop)      level_q <= level_q + LW'(1);
      else if (!wr_en && pop) level_q <= level_q - LW'(1);
      ovf_q <= ovf_q | ovf_set;
    end
  end

  // Storage needs no reset: word_o is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !bus.clear_i && wr_en) mem_q[wptr_q] <= acc_next;
  end

  assign bus.valid_o    = (level_q != '0);
  assign bus.word_o     = bus.valid_o ? mem_q[rptr_q] : '0;
  assign bus.level_o    = level_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_hyperbus_ddr_deser.sv
// Self-checking bench for hyperbus_ddr_deser (WIDTH=8, BEATS=2, DEPTH=2).
// The driver turns each DDR beat into a pair value and groups pairs into
// words; completed words are scheduled into a queue-based FIFO model that
// tracks occupancy, drops on overflow and flushes on clear/reset. A monitor
// compares the DUT outputs against that model on every falling edge.
module tb_hyperbus_ddr_deser;
  localparam int W  = 8;
  localparam int B  = 2;
  localparam int D  = 2;
  localparam int WW = 2 * W * B;

  logic clk;
  logic rst_n;

  hyperbus_ddr_deser_if #(.WIDTH(W), .BEATS(B), .DEPTH(D)) bus ();

  hyperbus_ddr_deser #(.WIDTH(W), .BEATS(B), .DEPTH(D)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [WW-1:0] w;
    int            due;
  } pend_t;

  logic [WW-1:0]  exp_q[$];
  pend_t          pend_q[$];
  logic [2*W-1:0] pairs_q[$];
  bit             m_ovf;
  int             cyc;
  bit             mon_on;
  bit             rnd_rdy;
  int             checks;
  int             errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of whole words, updated on each rising edge.
  initial begin
    logic [WW-1:0] w;
    bit do_push, do_pop, was_full;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n || bus.clear_i) begin
        exp_q.delete();
        pend_q.delete();
        pairs_q.delete();
        m_ovf = 1'b0;
      end else begin
        do_pop  = (exp_q.size() > 0) && bus.ready_i;
        do_push = 1'b0;
        w       = '0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          w       = pend_q[0].w;
          do_push = 1'b1;
          void'(pend_q.pop_front());
        end
        was_full = (exp_q.size() == D);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
          if (was_full && !do_pop) m_ovf = 1'b1;
          else exp_q.push_back(w);
        end
      end
    end
  end

  // Monitor: compare outputs with the model away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("valid", bus.valid_o, exp_q.size() != 0);
        chk("level", bus.level_o, exp_q.size());
        chk("overflow", bus.overflow_o, m_ovf);
        if (exp_q.size() != 0) chk("head_word", bus.word_o, exp_q[0]);
        else                   chk("empty_word", bus.word_o, 0);
      end
    end
  end

  // Random back-pressure, only during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rnd_rdy) bus.ready_i = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  // One DDR beat: r is presented for the rising edge, f for the falling edge.
  task automatic beat(input logic [W-1:0] r, input logic [W-1:0] f);
    logic [WW-1:0] w;
    @(negedge clk);
    #2;
    bus.data_i   = r;
    bus.enable_i = 1'b1;
    @(posedge clk);
    #2;
    pairs_q.push_back(bus.pos_first_i ? {f, r} : {r, f});
    if (pairs_q.size() == B) begin
      w = '0;
      for (int i = 0; i < B; i++) w[i*2*W +: 2*W] = pairs_q[i];
      // Pair forms one edge later, the word is written on the edge after.
      pend_q.push_back('{w: w, due: cyc + 2});
      pairs_q.delete();
    end
    bus.data_i = f;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
      bus.enable_i = 1'b0;
      bus.data_i   = W'($urandom);
    end
  endtask

  task automatic drain();
    bus.ready_i = 1'b1;
    idle(4);
    bus.ready_i = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); #2; bus.clear_i = 1'b1;
    @(negedge clk); #2; bus.clear_i = 1'b0;
  endtask

  task automatic rand_word();
    beat(W'($urandom), W'($urandom));
    beat(W'($urandom), W'($urandom));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks       = 0;
    errors       = 0;
    mon_on       = 1'b0;
    rnd_rdy      = 1'b0;
    rst_n        = 1'b0;
    bus.enable_i = 1'b0;
    bus.data_i   = '0;
    bus.pos_first_i = 1'b1;
    bus.clear_i  = 1'b0;
    bus.ready_i  = 1'b0;

    repeat (2) @(posedge clk);
    #2 mon_on = 1'b1;
    repeat (2) @(posedge clk);
    chk("reset_valid", bus.valid_o, 0);
    chk("reset_word", bus.word_o, 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Basic word, rising sample in the low half
    beat(8'h11, 8'h22); beat(8'h33, 8'h44); idle(3);
    chk("basic_word", bus.word_o, 32'h44332211);
    chk("basic_level", bus.level_o, 1);
    drain();

    // Legacy ordering
    bus.pos_first_i = 1'b0;
    beat(8'h11, 8'h22); beat(8'h33, 8'h44); idle(3);
    chk("legacy_word", bus.word_o, 32'h33441122);
    drain();
    bus.pos_first_i = 1'b1;

    // Gap in enable keeps the partial word
    beat(8'ha1, 8'hb2); idle(5);
    chk("gap_no_word", bus.valid_o, 0);
    beat(8'hc3, 8'hd4); idle(3);
    chk("gap_word", bus.word_o, 32'hd4c3b2a1);
    chk("gap_level", bus.level_o, 1);
    drain();

    // Overflow: third word dropped, first two kept in order
    rand_word(); rand_word(); rand_word(); idle(3);
    chk("ovf_level", bus.level_o, 2);
    chk("ovf_flag", bus.overflow_o, 1);
    drain();
    chk("ovf_sticky", bus.overflow_o, 1);
    pulse_clear();
    chk("ovf_cleared", bus.overflow_o, 0);

    // Full FIFO with push and pop on the same edge
    rand_word(); rand_word(); idle(3);
    chk("full_level", bus.level_o, 2);
    rand_word();
    @(negedge clk); #2 bus.enable_i = 1'b0;
    @(negedge clk); #2 bus.ready_i = 1'b1;
    @(negedge clk); #2 bus.ready_i = 1'b0;
    chk("full_pushpop_level", bus.level_o, 2);
    chk("full_pushpop_ovf", bus.overflow_o, 0);
    drain();

    // Clear with a partial word and one queued word
    rand_word(); beat(8'h5a, 8'ha5); idle(3);
    chk("pre_clear_level", bus.level_o, 1);
    pulse_clear();
    chk("clear_valid", bus.valid_o, 0);
    chk("clear_level", bus.level_o, 0);
    beat(8'h55, 8'h66); beat(8'h77, 8'h88); idle(3);
    chk("clear_fresh_word", bus.word_o, 32'h88776655);
    drain();

    // Reset mid-word discards the partial beat
    beat(8'h01, 8'h02); idle(3);
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    chk("rst_mid_valid", bus.valid_o, 0);
    beat(8'h0a, 8'h0b); beat(8'h0c, 8'h0d); idle(3);
    chk("rst_mid_word", bus.word_o, 32'h0d0c0b0a);
    drain();

    // Random traffic with random back-pressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      else beat(W'($urandom), W'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        idle(2);
        bus.pos_first_i = 1'($urandom_range(0, 1));
      end
    end
    idle(3);
    rnd_rdy = 1'b0;
    #2;
    bus.ready_i = 1'b1;
    idle(8);
    chk("final_drain", bus.valid_o, 0);
    chk("final_model_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
